// File: rtl/config_connection_block.sv
`default_nettype none
// ============================================================================
// Module      : config_connection_block
// Description : Connection block for one fabric tile. Joins NCLB adjacent
//               CLBs to NT = 2*(WS+WD) directional routing tracks through
//               configuration-driven multiplexers. There are no tristates.
//
//               Configuration shifts serially into a shadow chain. On a
//               commit request the chain is copied into the active
//               configuration in one step, but only if exactly CFG_BITS bits
//               arrived since the last commit and the chain has even parity.
//
// Ports       :
//   clk         fabric clock
//   rst         synchronous, active-high reset
//   cen         configuration shift enable
//   shift_in    configuration serial data in
//   set_in      commit request (single-cycle pulse)
//   shift_out   configuration serial data out (shadow MSB)
//   cfg_valid   an active configuration has been committed
//   cfg_err     the most recent commit request was rejected
//   trk_in      track inputs; low half = side 0, high half = side 1
//   trk_out     track outputs; same index map as trk_in
//   clb_output  CLB output pins; CLB n pin j at bit n*CLBOUT+j
//   clb_input   CLB input pins;  CLB n pin p at bit n*CLBIN+p
//   clb_cout    carry out of each CLB
//   clb_cin     carry into each CLB
//   carry_in    carry from the neighbouring tile
//   carry_out   carry to the neighbouring tile (last CLB's carry out)
//
// Revision    : 1.0 - initial release
// ============================================================================
module config_connection_block #(
    parameter int WS      = 4,   // single tracks per side
    parameter int WD      = 8,   // double tracks per side
    parameter int NCLB    = 2,   // adjacent CLBs served (1..4)
    parameter int CLBIN   = 10,  // input pins per CLB
    parameter int CLBOUT  = 5,   // output pins per CLB
    parameter int REG_OUT = 0    // 1 = register clb_input / trk_out
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cen,
    input  logic                       shift_in,
    input  logic                       set_in,
    output logic                       shift_out,
    output logic                       cfg_valid,
    output logic                       cfg_err,
    input  logic [2*(WS+WD)-1:0]       trk_in,
    output logic [2*(WS+WD)-1:0]       trk_out,
    input  logic [NCLB*CLBOUT-1:0]     clb_output,
    output logic [NCLB*CLBIN-1:0]      clb_input,
    input  logic [NCLB-1:0]            clb_cout,
    output logic [NCLB-1:0]            clb_cin,
    input  logic                       carry_in,
    output logic                       carry_out
);

    // ------------------------------------------------------------------------
    // Derived sizes and configuration bit map (LSB first):
    //   [BASE_T-1:0]            input-pin selects, SELI bits each
    //   [BASE_C-1:BASE_T]       track selects, SELO bits each
    //   [BASE_C+NCLB-1:BASE_C]  per-CLB carry enables
    //   [CFG_BITS-1]            parity bit (first bit shifted in)
    // ------------------------------------------------------------------------
    localparam int NT       = 2 * (WS + WD);
    localparam int NPIN     = NCLB * CLBIN;
    localparam int NOUT     = NCLB * CLBOUT;
    localparam int SELI     = $clog2(NT + 1);
    localparam int SELO     = $clog2(NOUT + 2);
    localparam int BASE_T   = NPIN * SELI;
    localparam int BASE_C   = BASE_T + NT * SELO;
    localparam int CFG_BITS = BASE_C + NCLB + 1;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    // ------------------------------------------------------------------------
    // Configuration storage
    // ------------------------------------------------------------------------
    logic [CFG_BITS-1:0] r_shadow;
    // The parity bit has no meaning once a load has been accepted, so the
    // active copy keeps only the payload below it.
    logic [CFG_BITS-2:0] r_active;
    logic [CNT_W-1:0]    r_count;
    logic                r_valid;
    logic                r_err;

    logic w_count_ok;
    logic w_parity_ok;
    logic w_accept;

    assign w_count_ok  = (r_count == CNT_FULL);
    assign w_parity_ok = ~(^r_shadow);
    // A commit that coincides with a shift is never accepted: the shadow is
    // changing under it.
    assign w_accept    = set_in & ~cen & w_count_ok & w_parity_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // Shift path. The counter saturates one past a full load so that
            // an over-long load is distinguishable from an exact one.
            if (cen) begin
                r_shadow <= {r_shadow[CFG_BITS-2:0], shift_in};
                if (r_count != CNT_SAT) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (set_in) begin
                // A commit restarts the bit count whether or not it is
                // accepted; a commit issued while shifting leaves it alone.
                r_count <= '0;
            end

            // Commit path. The whole payload moves in one clock, so the
            // muxes never see a partially updated configuration.
            if (set_in) begin
                if (w_accept) begin
                    r_active <= r_shadow[CFG_BITS-2:0];
                    r_valid  <= 1'b1;
                    r_err    <= 1'b0;
                end else begin
                    r_err    <= 1'b1;
                end
            end
        end
    end

    assign shift_out = r_shadow[CFG_BITS-1];
    assign cfg_valid = r_valid;
    assign cfg_err   = r_err;

    // ------------------------------------------------------------------------
    // CLB input-pin multiplexers
    //   sel 0        -> 0
    //   sel 1..NT    -> trk_in[sel-1]
    //   sel > NT     -> 0 (unused codes of the select field)
    // The result is forced to 0 until a configuration is committed.
    // ------------------------------------------------------------------------
    logic [NPIN-1:0] w_clb_input;

    for (genvar gp = 0; gp < NPIN; gp++) begin : g_pin
        logic [SELI-1:0] w_sel;
        logic            w_bit;

        assign w_sel = r_active[gp*SELI +: SELI];

        always_comb begin
            w_bit = 1'b0;
            for (int k = 1; k <= NT; k++) begin
                if (int'(w_sel) == k) begin
                    w_bit = trk_in[k-1];
                end
            end
        end

        assign w_clb_input[gp] = r_valid & w_bit;
    end

    // ------------------------------------------------------------------------
    // Track output multiplexers
    //   sel 0            -> same track index on the opposite side
    //   sel 1            -> 0 (track not driven by this block)
    //   sel 2+j, j<NOUT  -> clb_output[j]
    //   any other code   -> treated as passthrough
    // ------------------------------------------------------------------------
    logic [NT-1:0] w_trk_out;

    for (genvar gt = 0; gt < NT; gt++) begin : g_trk
        localparam int PASS = (gt + NT / 2) % NT;

        logic [SELO-1:0] w_sel;
        logic            w_bit;

        assign w_sel = r_active[BASE_T + gt*SELO +: SELO];

        always_comb begin
            w_bit = trk_in[PASS];
            if (int'(w_sel) == 1) begin
                w_bit = 1'b0;
            end else begin
                for (int j = 0; j < NOUT; j++) begin
                    if (int'(w_sel) == j + 2) begin
                        w_bit = clb_output[j];
                    end
                end
            end
        end

        assign w_trk_out[gt] = r_valid & w_bit;
    end

    // ------------------------------------------------------------------------
    // Carry chain. Always combinational, independent of REG_OUT, so a carry
    // can ripple through several tiles within one cycle.
    // ------------------------------------------------------------------------
    logic [NCLB-1:0] w_carry_en;

    assign w_carry_en = r_active[BASE_C +: NCLB];

    for (genvar gc = 0; gc < NCLB; gc++) begin : g_carry
        if (gc == 0) begin : g_first
            assign clb_cin[gc] = r_valid & w_carry_en[gc] & carry_in;
        end else begin : g_chain
            assign clb_cin[gc] = r_valid & w_carry_en[gc] & clb_cout[gc-1];
        end
    end

    assign carry_out = clb_cout[NCLB-1];

    // ------------------------------------------------------------------------
    // Optional output register stage for the routing muxes
    // ------------------------------------------------------------------------
    if (REG_OUT != 0) begin : g_reg_out
        logic [NPIN-1:0] r_clb_input;
        logic [NT-1:0]   r_trk_out;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_clb_input <= '0;
                r_trk_out   <= '0;
            end else begin
                r_clb_input <= w_clb_input;
                r_trk_out   <= w_trk_out;
            end
        end

        assign clb_input = r_clb_input;
        assign trk_out   = r_trk_out;
    end else begin : g_comb_out
        assign clb_input = w_clb_input;
        assign trk_out   = w_trk_out;
    end

endmodule
`default_nettype wire

// File: tb/tb_config_connection_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_connection_block
// Description : Self-checking bench for config_connection_block with default
//               parameters (REG_OUT = 0). A behavioural model holds the
//               shadow chain as a bit queue and the active configuration as
//               decoded select values; a negedge process compares every DUT
//               output against it each cycle. Directed literal checks pin
//               the model to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_connection_block;

    localparam int WS     = 4;
    localparam int WD     = 8;
    localparam int NCLB   = 2;
    localparam int CLBIN  = 10;
    localparam int CLBOUT = 5;
    localparam int NT     = 24;
    localparam int NPIN   = NCLB * CLBIN;
    localparam int NOUT   = NCLB * CLBOUT;
    localparam int SELI   = 5;
    localparam int SELO   = 4;
    localparam int BT     = NPIN * SELI;   // 100
    localparam int BC     = BT + NT * SELO; // 196
    localparam int CFG    = 199;

    logic              clk = 1'b0;
    logic              rst;
    logic              cen;
    logic              shift_in;
    logic              set_in;
    logic              shift_out;
    logic              cfg_valid;
    logic              cfg_err;
    logic [NT-1:0]     trk_in;
    logic [NT-1:0]     trk_out;
    logic [NOUT-1:0]   clb_output;
    logic [NPIN-1:0]   clb_input;
    logic [NCLB-1:0]   clb_cout;
    logic [NCLB-1:0]   clb_cin;
    logic              carry_in;
    logic              carry_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    config_connection_block #(
        .WS(WS), .WD(WD), .NCLB(NCLB), .CLBIN(CLBIN), .CLBOUT(CLBOUT), .REG_OUT(0)
    ) dut (
        .clk(clk), .rst(rst), .cen(cen), .shift_in(shift_in), .set_in(set_in),
        .shift_out(shift_out), .cfg_valid(cfg_valid), .cfg_err(cfg_err),
        .trk_in(trk_in), .trk_out(trk_out),
        .clb_output(clb_output), .clb_input(clb_input),
        .clb_cout(clb_cout), .clb_cin(clb_cin),
        .carry_in(carry_in), .carry_out(carry_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    //   m_q     : shadow chain, oldest bit first (front = MSB = shift_out)
    //   m_isel  : decoded input-pin selects of the active configuration
    //   m_tsel  : decoded track selects
    //   m_cen   : carry enables
    // ------------------------------------------------------------------------
    bit m_q[$];
    int m_cnt;
    bit m_valid;
    bit m_err;
    int m_isel[NPIN];
    int m_tsel[NT];
    bit m_cen[NCLB];

    // Value of shadow bits [lsb +: w]
    function automatic int field(int lsb, int w);
        int v = 0;
        for (int b = 0; b < w; b++) begin
            if (m_q[CFG-1-(lsb+b)]) v += (1 << b);
        end
        return v;
    endfunction

    function automatic bit queue_parity();
        bit p = 1'b0;
        foreach (m_q[k]) p ^= m_q[k];
        return p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q = {};
            for (int k = 0; k < CFG; k++) m_q.push_back(1'b0);
            m_cnt   = 0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            foreach (m_isel[p]) m_isel[p] = 0;
            foreach (m_tsel[i]) m_tsel[i] = 0;
            foreach (m_cen[n])  m_cen[n]  = 1'b0;
        end else begin
            if (set_in) begin
                if (cen) begin
                    m_err = 1'b1;
                end else begin
                    if (m_cnt == CFG && !queue_parity()) begin
                        for (int p = 0; p < NPIN; p++) m_isel[p] = field(p*SELI, SELI);
                        for (int i = 0; i < NT; i++)   m_tsel[i] = field(BT + i*SELO, SELO);
                        for (int n = 0; n < NCLB; n++) m_cen[n]  = m_q[CFG-1-(BC+n)];
                        m_valid = 1'b1;
                        m_err   = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_cnt = 0;
                end
            end
            if (cen) begin
                m_q.push_back(shift_in);
                void'(m_q.pop_front());
                if (m_cnt < CFG + 1) m_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : cmp
        logic [NPIN-1:0] e_in;
        logic [NT-1:0]   e_trk;
        logic [NCLB-1:0] e_cin;
        int s;
        if (chk_en) begin
            for (int p = 0; p < NPIN; p++) begin
                s = m_isel[p];
                e_in[p] = (m_valid && s >= 1 && s <= NT) ? trk_in[s-1] : 1'b0;
            end
            for (int i = 0; i < NT; i++) begin
                s = m_tsel[i];
                if (!m_valid)                    e_trk[i] = 1'b0;
                else if (s == 1)                 e_trk[i] = 1'b0;
                else if (s >= 2 && s - 2 < NOUT) e_trk[i] = clb_output[s-2];
                else                             e_trk[i] = trk_in[(i + NT/2) % NT];
            end
            for (int n = 0; n < NCLB; n++) begin
                e_cin[n] = m_valid && m_cen[n] && ((n == 0) ? carry_in : clb_cout[n-1]);
            end
            check("clb_input", clb_input, e_in);
            check("trk_out",   trk_out,   e_trk);
            check("clb_cin",   clb_cin,   e_cin);
            check("carry_out", carry_out, clb_cout[NCLB-1]);
            check("shift_out", shift_out, m_q[0]);
            check("cfg_valid", cfg_valid, m_valid);
            check("cfg_err",   cfg_err,   m_err);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers. Inputs change 2 time units after a rising edge.
    // ------------------------------------------------------------------------
    int          c_isel[NPIN];
    int          c_tsel[NT];
    logic [1:0]  c_cen;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [CFG-1:0] pack(bit flip);
        logic [CFG-1:0] v;
        int tmp;
        v = '0;
        for (int p = 0; p < NPIN; p++) begin
            tmp = c_isel[p];
            for (int b = 0; b < SELI; b++) v[p*SELI + b] = tmp[b];
        end
        for (int i = 0; i < NT; i++) begin
            tmp = c_tsel[i];
            for (int b = 0; b < SELO; b++) v[BT + i*SELO + b] = tmp[b];
        end
        v[BC]      = c_cen[0];
        v[BC+1]    = c_cen[1];
        v[CFG-1]   = (^v[CFG-2:0]) ^ flip;
        return v;
    endfunction

    task automatic shift_bit(input bit b);
        cen      = 1'b1;
        shift_in = b;
        tick();
        cen      = 1'b0;
    endtask

    // Shift the first nbits of the packed configuration, MSB (parity) first
    task automatic load(input int nbits, input bit flip);
        logic [CFG-1:0] v;
        v = pack(flip);
        for (int k = 0; k < nbits; k++) shift_bit(v[CFG-1-k]);
    endtask

    task automatic commit();
        set_in = 1'b1;
        tick();
        set_in = 1'b0;
    endtask

    task automatic cfg_clear(input int isel, input int tsel, input logic [1:0] ce);
        foreach (c_isel[p]) c_isel[p] = isel;
        foreach (c_tsel[i]) c_tsel[i] = tsel;
        c_cen = ce;
    endtask

    bit sb[250];

    initial begin
        rst = 1'b1; cen = 1'b0; shift_in = 1'b0; set_in = 1'b0;
        trk_in = '0; clb_output = '0; clb_cout = '0; carry_in = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: isolation before any commit
        trk_in = '1; clb_output = '1; clb_cout = '1; carry_in = 1'b1;
        tick(); #1;
        check("iso_clb_input", clb_input, 0);
        check("iso_trk_out",   trk_out,   0);
        check("iso_clb_cin",   clb_cin,   0);
        check("iso_valid",     cfg_valid, 0);
        check("iso_err",       cfg_err,   0);
        trk_in = '0; clb_output = '0; clb_cout = '0; carry_in = 1'b0;

        // 2: clb0 pin0 <- trk_in[0], all tracks undriven
        cfg_clear(0, 1, 2'b00);
        c_isel[0] = 1;
        load(CFG, 1'b0);
        commit(); #1;
        check("t2_valid", cfg_valid, 1);
        check("t2_err",   cfg_err,   0);
        trk_in = 24'h000001; #1;
        check("t2_pin0_hi", clb_input, 20'h00001);
        check("t2_trk_out", trk_out, 24'h000000);
        tick();
        trk_in = 24'hFFFFFE; #1;
        check("t2_pin0_lo", clb_input, 20'h00000);
        tick();

        // 3: short load, parity error, then a good load of a mixed config
        for (int p = 0; p < NPIN; p++) c_isel[p] = int'($urandom_range(0, 31));
        for (int i = 0; i < NT; i++)   c_tsel[i] = int'($urandom_range(0, 15));
        c_cen = 2'($urandom_range(0, 3));
        load(CFG - 1, 1'b0);
        commit(); #1;
        check("t3_short_err",   cfg_err,   1);
        check("t3_short_valid", cfg_valid, 1);
        trk_in = 24'h000001; #1;
        check("t3_old_cfg", clb_input, 20'h00001);
        load(CFG, 1'b1);
        commit(); #1;
        check("t3_par_err", cfg_err, 1);
        load(CFG, 1'b0);
        commit(); #1;
        check("t3_good_err", cfg_err, 0);
        for (int c = 0; c < 30; c++) begin
            trk_in     = 24'($urandom);
            clb_output = 10'($urandom);
            clb_cout   = 2'($urandom);
            carry_in   = 1'($urandom);
            tick();
        end
        trk_in = '0; clb_output = '0; clb_cout = '0; carry_in = 1'b0;

        // 4: track 0 passthrough, CLB output, out-of-range code
        cfg_clear(0, 1, 2'b00);
        c_tsel[0] = 0;
        load(CFG, 1'b0); commit();
        trk_in = 24'h001000; #1;
        check("t4_pass", trk_out, 24'h000001);
        c_tsel[0] = 2;
        load(CFG, 1'b0); commit();
        trk_in = '0; clb_output = 10'h001; #1;
        check("t4_clbout", trk_out, 24'h000001);
        c_tsel[0] = 15;
        load(CFG, 1'b0); commit();
        clb_output = '0; trk_in = 24'h001000; #1;
        check("t4_oor_pass_hi", trk_out, 24'h000001);
        trk_in = 24'h000000; clb_output = '1; #1;
        check("t4_oor_pass_lo", trk_out, 24'h000000);
        tick();
        clb_output = '0;

        // 5: carry chain
        cfg_clear(0, 1, 2'b11);
        load(CFG, 1'b0); commit();
        carry_in = 1'b1; clb_cout = 2'b00; #1;
        check("t5_cin0", clb_cin, 2'b01);
        clb_cout = 2'b01; #1;
        check("t5_cin01", clb_cin, 2'b11);
        clb_cout = 2'b10; #1;
        check("t5_carry_out", carry_out, 1);
        tick();
        c_cen = 2'b01;
        load(CFG, 1'b0); commit();
        clb_cout = 2'b01; carry_in = 1'b1; #1;
        check("t5_cin1_off", clb_cin, 2'b01);
        tick();
        clb_cout = '0; carry_in = 1'b0;

        // 6: serial passthrough, commit while shifting, reset mid-load
        for (int k = 0; k < 250; k++) begin
            sb[k] = 1'($urandom);
            shift_bit(sb[k]);
            if (k >= CFG - 1) begin
                #1;
                check("t6_delay", shift_out, sb[k-(CFG-1)]);
            end
        end
        cen = 1'b1; set_in = 1'b1; shift_in = 1'b0;
        tick();
        cen = 1'b0; set_in = 1'b0; #1;
        check("t6_set_cen_err", cfg_err, 1);
        cfg_clear(0, 1, 2'b00);
        c_isel[0] = 1;
        load(100, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("t6_rst_valid", cfg_valid, 0);
        check("t6_rst_shift", shift_out, 0);
        load(CFG, 1'b0);
        commit(); #1;
        check("t6_reload_valid", cfg_valid, 1);
        check("t6_reload_err",   cfg_err,   0);
        tick(); tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
